// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: datapath width, op codes, FSM states.
package alu_pkg;

    localparam int unsigned W = 32;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_XOR = 4'd3,
        ALU_NOR = 4'd4,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_SLL = 4'd8,
        ALU_SRL = 4'd9,
        ALU_SRA = 4'd10
    } alu_op_e;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Upstream operand handshake and downstream result handshake of the execute stage.
interface alu_exec_stage_if;

    logic                    in_valid;
    logic                    in_ready;
    logic [3:0]              alu_op;
    logic [alu_pkg::W-1:0]   a;
    logic [alu_pkg::W-1:0]   b;
    logic [4:0]              shamt;
    logic                    out_valid;
    logic                    out_ready;
    logic [alu_pkg::W-1:0]   result;
    logic                    zero;
    logic                    overflow;

    // Driver side: presents operations, consumes results.
    modport master (
        output in_valid, alu_op, a, b, shamt, out_ready,
        input  in_ready, out_valid, result, zero, overflow
    );

    // Execute stage side.
    modport slave (
        input  in_valid, alu_op, a, b, shamt, out_ready,
        output in_ready, out_valid, result, zero, overflow
    );

endinterface

// File: rtl/alu_shift_seq.sv
// Iterative one-bit-per-cycle shifter; done is high in the cycle the final shift happens.
module alu_shift_seq
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [W-1:0] value,
    input  logic [4:0]   amt,
    output logic         done,
    output logic [W-1:0] shout
);

    logic [W-1:0] shreg;
    logic [4:0]   cnt;
    logic [3:0]   kind;
    logic [W-1:0] shifted;

    // Single-bit shift of the working register according to the latched shift kind.
    always_comb begin
        shifted = {shreg[W-2:0], 1'b0};
        if (kind == ALU_SRL) begin
            shifted = {1'b0, shreg[W-1:1]};
        end else if (kind == ALU_SRA) begin
            shifted = {shreg[W-1], shreg[W-1:1]};
        end
    end

    // Load on start, then shift and count down until the counter empties.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
            cnt   <= '0;
            kind  <= ALU_SLL;
        end else if (start) begin
            shreg <= value;
            cnt   <= amt;
            kind  <= op;
        end else if (cnt != 5'd0) begin
            shreg <= shifted;
            cnt   <= cnt - 5'd1;
        end
    end

    assign done  = (cnt == 5'd1);
    assign shout = shifted;

endmodule

// File: rtl/alu_exec_stage.sv
// Registered MIPS execute-stage ALU with valid/ready handshake and iterative shifts.
module alu_exec_stage
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    alu_exec_stage_if.slave bus
);

    state_e       state, state_next;
    logic         in_ready;
    logic         accept;
    logic         shift_start;
    logic         sh_done;
    logic         sh_fin;
    logic [W-1:0] sh_out;
    logic [W-1:0] op_res;
    logic         op_ovf;
    logic         load;
    logic [W-1:0] load_res;
    logic         load_ovf;
    logic [W-1:0] add_sum;
    logic [W-1:0] sub_beff;
    logic [W-1:0] sub_sum;
    logic [W:0]   diff;
    logic         out_valid_q;
    logic [W-1:0] result_q;
    logic         zero_q;
    logic         ovf_q;

    alu_shift_seq u_shift (
        .clk   (clk),
        .reset (reset),
        .start (shift_start),
        .op    (bus.alu_op),
        .value (bus.b),
        .amt   (bus.shamt),
        .done  (sh_done),
        .shout (sh_out)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: enter SHIFT on a nonzero-amount shift, leave on the final shift.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (shift_start) state_next = ST_SHIFT;
            ST_SHIFT: if (sh_done)     state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: readiness, acceptance and shifter start/finish strobes.
    always_comb begin
        in_ready    = (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
        accept      = bus.in_valid && in_ready;
        shift_start = accept && is_shift_op(bus.alu_op) && (bus.shamt != 5'd0);
        sh_fin      = (state == ST_SHIFT) && sh_done;
    end

    // Combinational op mux; SLT takes the sign of the 33-bit difference so SUB overflow cannot flip it.
    always_comb begin
        add_sum  = bus.a + bus.b;
        sub_beff = ~bus.b + 1'b1;
        sub_sum  = bus.a + sub_beff;
        diff     = {bus.a[W-1], bus.a} - {bus.b[W-1], bus.b};
        op_res   = '0;
        op_ovf   = 1'b0;
        case (bus.alu_op)
            ALU_AND: op_res = bus.a & bus.b;
            ALU_OR:  op_res = bus.a | bus.b;
            ALU_XOR: op_res = bus.a ^ bus.b;
            ALU_NOR: op_res = ~(bus.a | bus.b);
            ALU_ADD: begin
                op_res = add_sum;
                op_ovf = (bus.a[W-1] == bus.b[W-1]) && (add_sum[W-1] != bus.a[W-1]);
            end
            ALU_SUB: begin
                op_res = sub_sum;
                op_ovf = (bus.a[W-1] == sub_beff[W-1]) && (sub_sum[W-1] != bus.a[W-1]);
            end
            ALU_SLT: op_res = {{(W-1){1'b0}}, diff[W]};
            ALU_SLL, ALU_SRL, ALU_SRA: op_res = bus.b;
            default: op_res = '0;
        endcase
    end

    // Select what loads into the output register this cycle.
    always_comb begin
        load     = sh_fin || (accept && !shift_start);
        load_res = sh_fin ? sh_out : op_res;
        load_ovf = sh_fin ? 1'b0 : op_ovf;
    end

    // Output register: load a fresh result, otherwise hold until consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            result_q    <= load_res;
            zero_q      <= (load_res == '0);
            ovf_q       <= load_ovf;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: vector table plus handshake / reset corner sequences.
module tb_alu_exec_stage;
    import alu_pkg::*;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        z;
        logic        ov;
        int unsigned lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ov;
    } exp_t;

    localparam int unsigned NVEC = 20;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_exec_stage_if bus ();

    alu_exec_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    vec_t        vecs [NVEC];
    exp_t        sb [$];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard monitor: every consumed result must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL sb_empty: got result %h, required no output (t=%0t)", bus.result, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_result",   bus.result,          e.res);
                check("sb_zero",     32'(bus.zero),       32'(e.z));
                check("sb_overflow", 32'(bus.overflow),   32'(e.ov));
            end
        end
    end

    // Present an op, wait (bounded) for acceptance, then scramble operands to prove capture.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic push, input exp_t e);
        logic ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.a        = a;
        bus.b        = b;
        bus.shamt    = sh;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                if (push) sb.push_back(e);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL accept_timeout: got in_ready 0 for 64 cycles, required 1");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.alu_op   = 4'($urandom);
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.shamt    = 5'($urandom);
    endtask

    // Count negedges from acceptance to out_valid, and how many of those had in_ready low.
    task automatic wait_out(output int unsigned lat, output int unsigned lowr);
        lat  = 0;
        lowr = 0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) break;
            if (!bus.in_ready) lowr++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        dummy;
        int unsigned lat, lowr, seen;

        vecs[0]  = '{ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0, 1'b0, 1};
        vecs[1]  = '{ALU_NOR, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h000F000F, 1'b0, 1'b0, 1};
        vecs[2]  = '{ALU_OR,  32'h12345678, 32'h0F0F0000, 5'd0,  32'h1F3F5678, 1'b0, 1'b0, 1};
        vecs[3]  = '{ALU_XOR, 32'hFFFF0000, 32'hFFFF0000, 5'd0,  32'h00000000, 1'b1, 1'b0, 1};
        vecs[4]  = '{ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0, 1'b1, 1};
        vecs[5]  = '{ALU_ADD, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b1, 1'b0, 1};
        vecs[6]  = '{ALU_SUB, 32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b1, 1'b0, 1};
        vecs[7]  = '{ALU_SUB, 32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b0, 1'b1, 1};
        vecs[8]  = '{ALU_SLT, 32'h80000000, 32'h00000001, 5'd0,  32'h00000001, 1'b0, 1'b0, 1};
        vecs[9]  = '{ALU_SLT, 32'h00000001, 32'h80000000, 5'd0,  32'h00000000, 1'b1, 1'b0, 1};
        vecs[10] = '{ALU_SLT, 32'h80000000, 32'h7FFFFFFF, 5'd0,  32'h00000001, 1'b0, 1'b0, 1};
        vecs[11] = '{4'd5,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h00000000, 1'b1, 1'b0, 1};
        vecs[12] = '{4'd15,   32'h00000001, 32'h00000001, 5'd3,  32'h00000000, 1'b1, 1'b0, 1};
        vecs[13] = '{ALU_SLL, 32'hFFFFFFFF, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0, 1'b0, 1};
        vecs[14] = '{ALU_SRA, 32'hFFFFFFFF, 32'h80000010, 5'd4,  32'hF8000001, 1'b0, 1'b0, 5};
        vecs[15] = '{ALU_SRL, 32'hFFFFFFFF, 32'h80000000, 5'd31, 32'h00000001, 1'b0, 1'b0, 32};
        vecs[16] = '{ALU_SLL, 32'hFFFFFFFF, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 1'b0, 32};
        vecs[17] = '{ALU_SRL, 32'hFFFFFFFF, 32'hF0000000, 5'd4,  32'h0F000000, 1'b0, 1'b0, 5};
        vecs[18] = '{ALU_SRA, 32'hFFFFFFFF, 32'h70000000, 5'd3,  32'h0E000000, 1'b0, 1'b0, 4};
        vecs[19] = '{ALU_SLL, 32'h00000000, 32'h00000003, 5'd1,  32'h00000006, 1'b0, 1'b0, 2};
        dummy = '{32'h0, 1'b0, 1'b0};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.alu_op    = 4'd0;
        bus.a         = '0;
        bus.b         = '0;
        bus.shamt     = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result",    bus.result,         32'd0);
        check("rst_zero",      32'(bus.zero),      32'd0);
        check("rst_overflow",  32'(bus.overflow),  32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk);
        #1;

        // Vector table: values via scoreboard, latency and in_ready-low cycles checked here.
        for (int i = 0; i < int'(NVEC); i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, 1'b1,
                 '{vecs[i].res, vecs[i].z, vecs[i].ov});
            wait_out(lat, lowr);
            check("latency",       lat,  vecs[i].lat);
            check("in_ready_busy", lowr, vecs[i].lat - 1);
        end

        // Backpressure: result held, in_ready low, then accept-on-release and streaming.
        bus.out_ready = 1'b0;
        send(ALU_ADD, 32'd10, 32'd20, 5'd0, 1'b1, '{32'd30, 1'b0, 1'b0});
        bus.in_valid = 1'b1;
        bus.alu_op   = ALU_ADD;
        bus.a        = 32'd1;
        bus.b        = 32'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready",  32'(bus.in_ready),  32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_result",    bus.result,         32'd30);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.alu_op = ALU_ADD;
            bus.a      = 32'(32'h1000 * (i + 1));
            bus.b      = 32'(i + 3);
            @(negedge clk);
            check("stream_ready", 32'(bus.in_ready),  32'd1);
            check("stream_valid", 32'(bus.out_valid), 32'd1);
            if (bus.in_ready) sb.push_back('{32'(32'h1000 * (i + 1) + i + 3), 1'b0, 1'b0});
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stream_drained", sb.size(), 32'd0);

        // Reset during the 5th SHIFT cycle of SLL by 20: op is discarded.
        send(ALU_SLL, 32'd0, 32'd1, 5'd20, 1'b0, dummy);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("shift_busy", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_result",    bus.result,         32'd0);
        check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("no_stale_result", seen, 32'd0);
        @(posedge clk);
        #1;

        // Normal operation resumes after the mid-shift reset.
        send(ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 1'b1, '{32'hF000F000, 1'b0, 1'b0});
        wait_out(lat, lowr);
        check("post_rst_latency", lat, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("final_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
